lsu_dcache_port: RTL and testbench

- Load/store initiator that drives the word-wide L1 data cache (single address, write-data, write-enable, synchronous read-data) on behalf of the execute stage.
- Converts RV32I byte/halfword/word loads and stores into cache word accesses.
- Sub-word stores use read-modify-write; sign/zero extension is applied to loads.
- Sits between the execute stage and the data cache, handshaking with the pipeline via valid/ready.

---
 rtl/lsu_dcache_port.sv | 158 +++++++++++++++
 tb/tb_lsu_dcache_port.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_dcache_port.sv
// rtl/lsu_dcache_port.sv - RV32I load/store initiator for a word-wide synchronous-read L1 data cache
//
// Ports:
//   clk, rst_n                    clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready           pipeline request handshake (ready only in IDLE)
//   req_we, req_addr, req_wdata   store flag, byte address, store data
//   req_funct3                    RV32I width/sign code (b, h, w, bu, hu)
//   resp_valid                    one-cycle completion pulse
//   resp_rdata, resp_err          extended load data / error flag, held until the next completion
//   dc_a, dc_wd, dc_we            cache word address, write data, write enable
//   dc_rd                         cache read data, valid the cycle after a read address
module lsu_dcache_port #(
    parameter int N = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [31:0]          req_addr,
    input  logic [31:0]          req_wdata,
    input  logic [2:0]           req_funct3,
    output logic                 resp_valid,
    output logic [31:0]          resp_rdata,
    output logic                 resp_err,
    output logic [$clog2(N)-1:0] dc_a,
    output logic [31:0]          dc_wd,
    output logic                 dc_we,
    input  logic [31:0]          dc_rd
);
    localparam int AW = $clog2(N);
    localparam logic [32:0] LIMIT = 33'(4 * N);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_RD_ISSUE = 3'd1;
    localparam logic [2:0] S_RD_DATA  = 3'd2;
    localparam logic [2:0] S_WR       = 3'd3;
    localparam logic [2:0] S_RESP     = 3'd4;

    logic [2:0]    state;
    logic          we_q;
    logic [AW+1:0] addr_q;
    logic [15:0]   wdata_q;      // only the low half is ever merged into a sub-word store
    logic [2:0]    f3_q;
    logic [31:0]   wd_q;

    logic        req_err;
    logic        illegal;
    logic        misaligned;
    logic        out_of_range;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_ext;
    logic [31:0] lane_mask;
    logic [31:0] lane_data;
    logic [31:0] merged;

    // Request legality, evaluated on the live request at accept time.
    always_comb begin
        illegal = 1'b1;
        case (req_funct3)
            3'b000, 3'b001, 3'b010: illegal = 1'b0;
            3'b100, 3'b101:         illegal = req_we;
            default:                illegal = 1'b1;
        endcase
        misaligned   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                       ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        out_of_range = ({1'b0, req_addr} >= LIMIT);
        req_err      = illegal || misaligned || out_of_range;
    end

    // Load extraction and sub-word store merge, both from the word read in RD_DATA.
    always_comb begin
        case (addr_q[1:0])
            2'd0:    byte_sel = dc_rd[7:0];
            2'd1:    byte_sel = dc_rd[15:8];
            2'd2:    byte_sel = dc_rd[23:16];
            default: byte_sel = dc_rd[31:24];
        endcase
        half_sel = addr_q[1] ? dc_rd[31:16] : dc_rd[15:0];

        case (f3_q)
            3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  load_ext = {24'h0, byte_sel};
            3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
            3'b101:  load_ext = {16'h0, half_sel};
            default: load_ext = dc_rd;
        endcase

        if (f3_q[1:0] == 2'b00) begin
            lane_mask = 32'h0000_00FF << {addr_q[1:0], 3'b000};
            lane_data = {4{wdata_q[7:0]}};
        end else begin
            lane_mask = addr_q[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
            lane_data = {2{wdata_q}};
        end
        merged = (dc_rd & ~lane_mask) | (lane_data & lane_mask);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            f3_q       <= '0;
            wd_q       <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        addr_q  <= req_addr[AW+1:0];
                        wdata_q <= req_wdata[15:0];
                        f3_q    <= req_funct3;
                        if (req_err) begin
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                            state      <= S_RESP;
                        end else if (req_we && (req_funct3[1:0] == 2'b10)) begin
                            // Full-word store needs no read; write straight away.
                            wd_q  <= req_wdata;
                            state <= S_WR;
                        end else begin
                            state <= S_RD_ISSUE;
                        end
                    end
                end
                S_RD_ISSUE: state <= S_RD_DATA;
                S_RD_DATA: begin
                    if (we_q) begin
                        wd_q  <= merged;
                        state <= S_WR;
                    end else begin
                        resp_rdata <= load_ext;
                        resp_err   <= 1'b0;
                        state      <= S_RESP;
                    end
                end
                S_WR: begin
                    resp_rdata <= '0;
                    resp_err   <= 1'b0;
                    state      <= S_RESP;
                end
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign req_ready  = (state == S_IDLE);
    assign resp_valid = (state == S_RESP);
    assign dc_we      = (state == S_WR);
    assign dc_a       = addr_q[AW+1:2];
    assign dc_wd      = wd_q;
endmodule

// File: tb/tb_lsu_dcache_port.sv
// tb/tb_lsu_dcache_port.sv - self-checking bench for lsu_dcache_port
module tb_lsu_dcache_port;
    localparam int N  = 1024;
    localparam int AW = $clog2(N);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [31:0]   req_addr = '0;
    logic [31:0]   req_wdata = '0;
    logic [2:0]    req_funct3 = '0;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          resp_err;
    logic [AW-1:0] dc_a;
    logic [31:0]   dc_wd;
    logic          dc_we;
    logic [31:0]   dc_rd;

    lsu_dcache_port #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .dc_a(dc_a), .dc_wd(dc_wd), .dc_we(dc_we), .dc_rd(dc_rd)
    );

    always #5 clk = ~clk;

    // Cache model: synchronous read, write on the rising edge.
    logic [31:0] mem [0:N-1];
    always @(posedge clk) begin
        if (dc_we) mem[dc_a] <= dc_wd;
        dc_rd <= mem[dc_a];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  f3;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          nwr;
        logic [31:0] wd;
    } vec_t;

    vec_t        vecs [16];
    vec_t        exp_q [$];
    int          acc_q [$];
    int          tests = 0;
    int          fails = 0;
    int          acc_total = 0;
    int          nwr = 0;
    logic [31:0] last_wd = '0;
    logic [AW-1:0] last_a = '0;
    int          last_acc = -100;
    bit          hold_chk = 1'b0;
    int          hold_acc = 0;
    int          hold_resp = 0;
    int          viol = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    task automatic monitor();
        vec_t e;
        int   a;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (dc_we) begin
                    nwr++;
                    last_wd = dc_wd;
                    last_a  = dc_a;
                end
                if (resp_valid) begin
                    if (hold_chk) hold_resp++;
                    if (exp_q.size() == 0 || acc_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_resp: resp_valid=1 with no request outstanding, required 0");
                    end else begin
                        e = exp_q.pop_front();
                        a = acc_q.pop_front();
                        check("resp_rdata", resp_rdata, e.rdata);
                        check("resp_err", 32'(resp_err), 32'(e.err));
                        check("latency", 32'(cyc - a + 1), 32'(e.lat));
                        check("write_count", 32'(nwr), 32'(e.nwr));
                        if (e.nwr > 0) begin
                            check("dc_wd", last_wd, e.wd);
                            check("dc_a", 32'(last_a), 32'(e.addr[AW+1:2]));
                        end
                    end
                end
                if (hold_chk && req_ready && (cyc - last_acc >= 0) && (cyc - last_acc <= 2)) viol++;
                if (req_valid && req_ready) begin
                    if (hold_chk && hold_acc > 0) check("accept_spacing", 32'(cyc + 1 - last_acc), 32'd4);
                    if (hold_chk) hold_acc++;
                    last_acc = cyc + 1;
                    acc_q.push_back(cyc + 1);
                    acc_total++;
                    nwr = 0;
                end
            end
        end
    endtask

    task automatic drive(input vec_t v);
        @(posedge clk); #2;
        req_we     = v.we;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        req_funct3 = v.f3;
        req_valid  = 1'b1;
    endtask

    task automatic wait_accepts(input int target);
        int k = 0;
        while (acc_total < target && k < 60) begin
            @(negedge clk); #1;
            k++;
        end
        if (acc_total < target) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: accepts %0d, required %0d", acc_total, target);
        end
        @(posedge clk); #2;
        req_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int k = 0;
        while (exp_q.size() != 0 && k < 40) begin
            @(negedge clk); #1;
            k++;
        end
        if (exp_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL resp_timeout: %0d responses missing, required 0", exp_q.size());
            exp_q.delete();
            acc_q.delete();
        end
    endtask

    task automatic run_vec(input vec_t v);
        int start;
        start = acc_total;
        exp_q.push_back(v);
        drive(v);
        wait_accepts(start + 1);
        wait_drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        vec_t v;
        int   start;
        int   k;

        for (int i = 0; i < N; i++) mem[i] <= '0;

        //           we    addr          wdata          f3      rdata          err  lat nwr wd
        vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 3'b010, 32'h0000_0000, 1'b0, 2, 1, 32'hDEAD_BEEF};
        vecs[1]  = '{1'b0, 32'h0000_0013, 32'h0,         3'b000, 32'hFFFF_FFDE, 1'b0, 3, 0, 32'h0};
        vecs[2]  = '{1'b0, 32'h0000_0013, 32'h0,         3'b100, 32'h0000_00DE, 1'b0, 3, 0, 32'h0};
        vecs[3]  = '{1'b0, 32'h0000_0010, 32'h0,         3'b001, 32'hFFFF_BEEF, 1'b0, 3, 0, 32'h0};
        vecs[4]  = '{1'b0, 32'h0000_0012, 32'h0,         3'b101, 32'h0000_DEAD, 1'b0, 3, 0, 32'h0};
        vecs[5]  = '{1'b1, 32'h0000_0011, 32'h0000_0055, 3'b000, 32'h0000_0000, 1'b0, 4, 1, 32'hDEAD_55EF};
        vecs[6]  = '{1'b0, 32'h0000_0010, 32'h0,         3'b010, 32'hDEAD_55EF, 1'b0, 3, 0, 32'h0};
        vecs[7]  = '{1'b0, 32'h0000_0012, 32'h0,         3'b010, 32'h0000_0000, 1'b1, 1, 0, 32'h0};
        vecs[8]  = '{1'b1, 32'h0000_0001, 32'h0000_1234, 3'b001, 32'h0000_0000, 1'b1, 1, 0, 32'h0};
        vecs[9]  = '{1'b0, 32'(4 * N),    32'h0,         3'b010, 32'h0000_0000, 1'b1, 1, 0, 32'h0};
        vecs[10] = '{1'b1, 32'h0000_0020, 32'h1111_1111, 3'b100, 32'h0000_0000, 1'b1, 1, 0, 32'h0};
        vecs[11] = '{1'b0, 32'h0000_0020, 32'h0,         3'b110, 32'h0000_0000, 1'b1, 1, 0, 32'h0};
        vecs[12] = '{1'b1, 32'h0000_0012, 32'h1234_ABCD, 3'b001, 32'h0000_0000, 1'b0, 4, 1, 32'hABCD_55EF};
        vecs[13] = '{1'b0, 32'h0000_0010, 32'h0,         3'b010, 32'hABCD_55EF, 1'b0, 3, 0, 32'h0};
        vecs[14] = '{1'b0, 32'h0000_0010, 32'h0,         3'b000, 32'hFFFF_FFEF, 1'b0, 3, 0, 32'h0};
        vecs[15] = '{1'b0, 32'(4 * N - 4), 32'h0,        3'b010, 32'h0000_0000, 1'b0, 3, 0, 32'h0};

        fork monitor(); join_none

        // Reset values while reset is held.
        repeat (3) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_dc_we", 32'(dc_we), 32'd0);
        check("rst_dc_a", 32'(dc_a), 32'd0);
        check("rst_dc_wd", dc_wd, 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) run_vec(vecs[i]);

        // Held request: three loads back to back.
        v = vecs[13];
        hold_acc  = 0;
        hold_resp = 0;
        viol      = 0;
        hold_chk  = 1'b1;
        start = acc_total;
        for (int i = 0; i < 3; i++) exp_q.push_back(v);
        drive(v);
        wait_accepts(start + 3);
        wait_drain();
        repeat (4) @(negedge clk);
        hold_chk = 1'b0;
        check("hold_resp_pulses", 32'(hold_resp), 32'd3);
        check("hold_ready_busy", 32'(viol), 32'd0);

        // Reset asserted during the write phase of a byte store.
        v = '{1'b1, 32'h0000_0010, 32'h0000_0077, 3'b000, 32'h0, 1'b0, 4, 1, 32'h0};
        start = acc_total;
        drive(v);
        wait_accepts(start + 1);
        k = 0;
        while (!dc_we && k < 10) begin
            @(negedge clk);
            k++;
        end
        check("abort_reached_wr", 32'(dc_we), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_dc_we", 32'(dc_we), 32'd0);
        check("abort_resp_valid", 32'(resp_valid), 32'd0);
        acc_q.delete();
        repeat (2) @(negedge clk);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(negedge clk); #1;
        check("abort_req_ready", 32'(req_ready), 32'd1);
        repeat (4) @(negedge clk);
        run_vec(vecs[13]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
